ebpf_lsu: RTL and testbench

//  Load/store unit between the eBPF execute stage and data_memory. Accepts byte-addressed
//  LDX/STX requests of size B/H/W/DW, checks natural alignment, and converts them to 64-bit

---
 rtl/ebpf_lsu_pkg.sv | 38 +++
 rtl/ebpf_lsu_if.sv | 35 +++
 rtl/ebpf_lsu_lane.sv | 23 ++
 rtl/ebpf_lsu.sv | 120 ++++++++++++
 tb/tb_ebpf_lsu.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebpf_lsu_pkg.sv
// Shared definitions for the eBPF load/store unit: size codes, FSM states, lane helpers.
package ebpf_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B  = 2'd0,
        SZ_H  = 2'd1,
        SZ_W  = 2'd2,
        SZ_DW = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // Natural alignment: an access of 1<<size bytes must start on a multiple of its size.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off[1:0] != 2'b00;
            SZ_DW:   return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ebpf_lsu_if.sv
// Request/response and data_memory signals of the LSU; slave is the LSU side.
interface ebpf_lsu_if #(
    parameter int MEM_ADDR_W = 11
);
    localparam int AW = MEM_ADDR_W + 3;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [AW-1:0]         req_addr;
    logic [63:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [63:0]           resp_rdata;
    logic                  mem_stb;
    logic [MEM_ADDR_W-1:0] mem_adr;
    logic                  mem_we;
    logic [3:0]            mem_ww;
    logic [63:0]           mem_dat_w;
    logic [63:0]           mem_dat_r;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, mem_dat_r,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_stb, mem_adr, mem_we, mem_ww, mem_dat_w
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, mem_dat_r,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_stb, mem_adr, mem_we, mem_ww, mem_dat_w
    );

endinterface

// File: rtl/ebpf_lsu_lane.sv
// Little-endian lane logic: extract a zero-extended lane, or merge store data into a word.
module ebpf_lsu_lane
    import ebpf_lsu_pkg::*;
(
    input  logic        merge,
    input  logic [63:0] word,
    input  logic [63:0] wdata,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    output logic [63:0] result
);
    logic [5:0]  sh;
    logic [63:0] mask;
    logic [63:0] extracted;
    logic [63:0] merged;

    assign sh        = {off, 3'b000};
    assign mask      = lane_mask(size);
    assign extracted = (word >> sh) & mask;
    assign merged    = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    assign result    = merge ? merged : extracted;

endmodule

// File: rtl/ebpf_lsu.sv
// eBPF load/store unit: aligned B/H/W/DW accesses onto a 64-bit word memory, RMW for sub-word stores.
module ebpf_lsu
    import ebpf_lsu_pkg::*;
#(
    parameter int MEM_ADDR_W = 11,
    parameter int DATA_W     = 64
)(
    input  logic       clk,
    input  logic       rst,
    ebpf_lsu_if.slave  bus
);
    localparam int AW = MEM_ADDR_W + 3;

    state_e              state, state_nx;
    logic                we_q;
    logic [1:0]          size_q;
    logic [AW-1:0]       addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   ld_lane;
    logic [DATA_W-1:0]   st_word;
    logic                accept;
    logic                ready, stb, mwe, rvalid, rerr;

    assign accept = bus.req_valid && (state == S_IDLE);

    ebpf_lsu_lane u_ld_lane (
        .merge  (1'b0),
        .word   (bus.mem_dat_r),
        .wdata  (64'd0),
        .off    (addr_q[2:0]),
        .size   (size_q),
        .result (ld_lane)
    );

    // For DW the merge mask covers the whole word, so wdata passes straight through.
    ebpf_lsu_lane u_st_lane (
        .merge  (1'b1),
        .word   (word_q),
        .wdata  (wdata_q),
        .off    (addr_q[2:0]),
        .size   (size_q),
        .result (st_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
            end
            if (state == S_READ) begin
                if (we_q) word_q  <= bus.mem_dat_r;
                else      rdata_q <= ld_lane;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        stb      = 1'b0;
        mwe      = 1'b0;
        rvalid   = 1'b0;
        rerr     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned(bus.req_size, bus.req_addr[2:0])) state_nx = S_ERR;
                    else if (bus.req_we && bus.req_size == SZ_DW)     state_nx = S_WRITE;
                    else                                             state_nx = S_READ;
                end
            end
            S_READ: begin
                stb      = 1'b1;
                state_nx = we_q ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                stb      = 1'b1;
                mwe      = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                rvalid   = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                rvalid   = 1'b1;
                rerr     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rvalid;
    assign bus.resp_err   = rerr;
    assign bus.resp_rdata = (state == S_DONE && !we_q) ? rdata_q : 64'd0;
    assign bus.mem_stb    = stb;
    assign bus.mem_we     = mwe;
    assign bus.mem_adr    = addr_q[AW-1:3];
    assign bus.mem_ww     = {2'b00, size_q};
    assign bus.mem_dat_w  = (state == S_WRITE) ? st_word : 64'd0;

endmodule

// File: tb/tb_ebpf_lsu.sv
// Bench for ebpf_lsu: directed scenarios plus random traffic against a byte-array memory model.
module tb_ebpf_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   vec = 0;
    int   miss = 0;

    ebpf_lsu_if #(.MEM_ADDR_W(11)) bus ();

    ebpf_lsu #(.MEM_ADDR_W(11), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:63];
    assign bus.mem_dat_r = mem[bus.mem_adr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
        end else if (bus.mem_we) begin
            mem[bus.mem_adr[5:0]] <= bus.mem_dat_w;
        end
    end

    // Reference model: memory as a flat little-endian byte array
    logic [7:0] ref_b [0:511];

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_b[idx*8 + i];
        return w;
    endfunction

    task automatic ref_apply(input logic we, input logic [1:0] sz, input int addr,
                             input logic [63:0] wd, output logic err,
                             output logic [63:0] rd, output int lat);
        int nb;
        nb  = 1 << sz;
        rd  = 64'd0;
        err = (addr % nb) != 0;
        if (err) lat = 1;
        else if (!we) begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_b[addr + i];
            lat = 2;
        end else begin
            for (int i = 0; i < nb; i++) ref_b[addr + i] = wd[8*i +: 8];
            lat = (sz == 2'd3) ? 2 : 3;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic [13:0] a,
                         input logic [63:0] wd, output int lat, output logic err,
                         output logic [63:0] rd, output int stb_n, output int we_n,
                         output logic [10:0] we_adr);
        int g;
        lat = 0; err = 1'bx; rd = 'x; stb_n = 0; we_n = 0; we_adr = 'x;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.mem_stb) stb_n++;
            if (bus.mem_we) begin
                we_n++;
                we_adr = bus.mem_adr;
            end
            if (bus.resp_valid) begin
                lat = n;
                err = bus.resp_err;
                rd  = bus.resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_clr = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 512; i++) ref_b[i] = 8'h00;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vec++; if (bus.req_ready !== 1'b1) begin miss++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
        vec++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin miss++;
            $display("FAIL reset_resp got=%b/%b want=0/0", bus.resp_valid, bus.resp_err); end
        vec++; if (bus.resp_rdata !== 64'd0) begin miss++; $display("FAIL reset_rdata got=%h want=0", bus.resp_rdata); end
        vec++; if (bus.mem_stb !== 1'b0 || bus.mem_we !== 1'b0) begin miss++;
            $display("FAIL reset_mem_ctl got=%b/%b want=0/0", bus.mem_stb, bus.mem_we); end
        vec++; if (bus.mem_adr !== 11'd0 || bus.mem_ww !== 4'd0 || bus.mem_dat_w !== 64'd0) begin miss++;
            $display("FAIL reset_mem_bus got=%h/%h/%h want=0/0/0", bus.mem_adr, bus.mem_ww, bus.mem_dat_w); end
    endtask

    task automatic test_dw();
        int lat, sn, wn, rl; logic e, re; logic [63:0] rd, rr; logic [10:0] wa;
        ref_apply(1'b1, 2'd3, 16, 64'h1122334455667788, re, rr, rl);
        issue(1'b1, 2'd3, 14'h0010, 64'h1122334455667788, lat, e, rd, sn, wn, wa);
        vec++; if (lat !== 2 || e !== 1'b0) begin miss++; $display("FAIL dw_store_lat got=%0d/%b want=2/0", lat, e); end
        vec++; if (wn !== 1 || wa !== 11'd2) begin miss++; $display("FAIL dw_store_we got=%0d@%0d want=1@2", wn, wa); end
        vec++; if (mem[2] !== 64'h1122334455667788) begin miss++; $display("FAIL dw_store_mem got=%h want=1122334455667788", mem[2]); end
        issue(1'b0, 2'd3, 14'h0010, 64'd0, lat, e, rd, sn, wn, wa);
        vec++; if (lat !== 2 || rd !== 64'h1122334455667788) begin miss++;
            $display("FAIL dw_load got=%0d/%h want=2/1122334455667788", lat, rd); end
    endtask

    task automatic test_byte_rmw();
        int lat, sn, wn, rl; logic e, re; logic [63:0] rd, rr; logic [10:0] wa;
        ref_apply(1'b1, 2'd0, 19, 64'hAB, re, rr, rl);
        issue(1'b1, 2'd0, 14'h0013, 64'hFFFF_FFFF_FFFF_FFAB, lat, e, rd, sn, wn, wa);
        vec++; if (lat !== 3 || e !== 1'b0 || wn !== 1) begin miss++;
            $display("FAIL sb_lat got=%0d/%b/%0d want=3/0/1", lat, e, wn); end
        vec++; if (mem[2] !== 64'h11223344AB667788) begin miss++; $display("FAIL sb_mem got=%h want=11223344ab667788", mem[2]); end
    endtask

    task automatic test_subword_loads();
        int lat, sn, wn; logic e; logic [63:0] rd; logic [10:0] wa;
        issue(1'b0, 2'd1, 14'h0016, 64'd0, lat, e, rd, sn, wn, wa);
        vec++; if (rd !== 64'h1122 || lat !== 2) begin miss++; $display("FAIL ldh got=%h/%0d want=1122/2", rd, lat); end
        issue(1'b0, 2'd2, 14'h0014, 64'd0, lat, e, rd, sn, wn, wa);
        vec++; if (rd !== 64'h11223344 || lat !== 2) begin miss++; $display("FAIL ldw got=%h/%0d want=11223344/2", rd, lat); end
        issue(1'b0, 2'd0, 14'h0017, 64'd0, lat, e, rd, sn, wn, wa);
        vec++; if (rd !== 64'h11 || lat !== 2) begin miss++; $display("FAIL ldb got=%h/%0d want=11/2", rd, lat); end
    endtask

    task automatic test_misalign();
        int lat, sn, wn; logic e; logic [63:0] rd; logic [10:0] wa;
        issue(1'b0, 2'd2, 14'h0012, 64'd0, lat, e, rd, sn, wn, wa);
        vec++; if (lat !== 1 || e !== 1'b1 || sn !== 0 || rd !== 64'd0) begin miss++;
            $display("FAIL mis_ldw got=%0d/%b/%0d/%h want=1/1/0/0", lat, e, sn, rd); end
        issue(1'b1, 2'd1, 14'h0011, 64'hBEEF, lat, e, rd, sn, wn, wa);
        vec++; if (lat !== 1 || e !== 1'b1 || sn !== 0 || wn !== 0) begin miss++;
            $display("FAIL mis_sth got=%0d/%b/%0d/%0d want=1/1/0/0", lat, e, sn, wn); end
        vec++; if (mem[2] !== ref_word(2)) begin miss++; $display("FAIL mis_mem got=%h want=%h", mem[2], ref_word(2)); end
    endtask

    task automatic test_reset_mid_store();
        int rv;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 14'h0010;
        bus.req_wdata = 64'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vec++; if (bus.mem_we !== 1'b1) begin miss++; $display("FAIL rst_mid_we_before got=%b want=1", bus.mem_we); end
        #1 rst = 1'b1;
        #1;
        vec++; if (bus.mem_we !== 1'b0) begin miss++; $display("FAIL rst_mid_we_drop got=%b want=0", bus.mem_we); end
        rv = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) rv++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) rv++;
        end
        vec++; if (rv !== 0) begin miss++; $display("FAIL rst_mid_resp got=%0d want=0", rv); end
        vec++; if (bus.req_ready !== 1'b1) begin miss++; $display("FAIL rst_mid_ready got=%b want=1", bus.req_ready); end
        vec++; if (mem[2] !== ref_word(2)) begin miss++; $display("FAIL rst_mid_mem got=%h want=%h", mem[2], ref_word(2)); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] resps [$];
        logic [63:0] exp_a, exp_b, rr;
        logic re, acc_b;
        int rl, busy_ready, g;
        ref_apply(1'b0, 2'd3, 16, 64'd0, re, exp_a, rl);
        ref_apply(1'b0, 2'd0, 19, 64'd0, re, exp_b, rl);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd3;
        bus.req_addr  = 14'h0010;
        g = 0;
        while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
        @(posedge clk);
        #1;
        bus.req_size = 2'd0;
        bus.req_addr = 14'h0013;
        acc_b = 1'b0;
        busy_ready = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.resp_valid) resps.push_back(bus.resp_rdata);
            if (!acc_b && bus.req_ready) begin
                if (resps.size() == 0) busy_ready++;
                @(posedge clk);
                #1 bus.req_valid = 1'b0;
                acc_b = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        vec++; if (busy_ready !== 0) begin miss++; $display("FAIL b2b_busy_ready got=%0d want=0", busy_ready); end
        vec++; if (resps.size() !== 2) begin miss++; $display("FAIL b2b_count got=%0d want=2", resps.size()); end
        else begin
            vec++; if (resps[0] !== exp_a || resps[1] !== exp_b) begin miss++;
                $display("FAIL b2b_order got=%h,%h want=%h,%h", resps[0], resps[1], exp_a, exp_b); end
        end
        rr = 64'd0;
    endtask

    task automatic test_random();
        int lat, sn, wn, rl, addr, nb;
        logic e, re, we;
        logic [1:0] sz;
        logic [63:0] rd, rr, wd;
        logic [10:0] wa;
        for (int k = 0; k < 150; k++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            addr = $urandom_range(0, 63) * 8;
            if ($urandom_range(0, 3) == 0) addr += $urandom_range(0, 7);
            else addr += nb * $urandom_range(0, 8 / nb - 1);
            wd = {$urandom, $urandom};
            ref_apply(we, sz, addr, wd, re, rr, rl);
            issue(we, sz, 14'(addr), wd, lat, e, rd, sn, wn, wa);
            vec++;
            if (lat !== rl || e !== re || rd !== rr) begin
                miss++;
                $display("FAIL rand_%0d we=%b sz=%0d a=%h got=%0d/%b/%h want=%0d/%b/%h",
                         k, we, sz, addr, lat, e, rd, rl, re, rr);
            end
        end
        for (int i = 0; i < 64; i++) begin
            vec++;
            if (mem[i] !== ref_word(i)) begin
                miss++;
                $display("FAIL rand_mem_%0d got=%h want=%h", i, mem[i], ref_word(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_dw();
        test_byte_rmw();
        test_subword_loads();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
